// File: rtl/gray_seek_ctrl_if.sv
// Command/status bundle between the seek front end and gray_seek_ctrl.
// The master drives the Gray target command; the slave reports position and step strobes.
interface gray_seek_ctrl_if #(
  parameter int WIDTH = 3
);
  logic             cmd_valid;
  logic [WIDTH-1:0] cmd_target;
  logic             cmd_ready;
  logic [WIDTH-1:0] pos;
  logic             step;
  logic             up;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_target,
    input  cmd_ready, pos, step, up, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_target,
    output cmd_ready, pos, step, up, busy, done
  );
endinterface

// File: rtl/gray_seek_ctrl.sv
// Gray seek controller: steps pos one code at a time toward a Gray target; GRAY_SEEK_SHORTEST_EN picks shortest direction.
// Latency: handshake T, first step T+2, then one step per DWELL cycles; cmd_ready is low (commands ignored) while busy.
module gray_seek_ctrl #(
  parameter int WIDTH = 3,
  parameter int DWELL = 4
) (
  input  logic            clk,
  input  logic            reset,
  gray_seek_ctrl_if.slave bus
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [2:0] {IDLE, DECIDE, STEP, WAIT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] pos_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] remaining;
  logic             up_q;
  logic [DW-1:0]    dwell_cnt;

  logic [WIDTH-1:0] pos_bin;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] next_bin;

`ifdef GRAY_SEEK_SHORTEST_EN
  localparam logic [WIDTH-1:0] HALF = WIDTH'(1) << (WIDTH - 1);
`endif

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] b2g(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Arithmetic is done in binary; wrap modulo 2^WIDTH falls out of the fixed width.
  always_comb begin
    pos_bin  = g2b(pos_q);
    diff     = g2b(target_q) - pos_bin;
    next_bin = up_q ? pos_bin + WIDTH'(1) : pos_bin - WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pos_q     <= '0;
      target_q  <= '0;
      remaining <= '0;
      up_q      <= 1'b0;
      dwell_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            target_q <= bus.cmd_target;
            state    <= DECIDE;
          end
        end
        DECIDE: begin
          if (diff == '0) begin
            state <= DONE;
          end else begin
`ifdef GRAY_SEEK_SHORTEST_EN
            // Exactly half way round is resolved upward.
            if (diff > HALF) begin
              up_q      <= 1'b0;
              remaining <= -diff;
            end else begin
              up_q      <= 1'b1;
              remaining <= diff;
            end
`else
            up_q      <= 1'b1;
            remaining <= diff;
`endif
            state <= STEP;
          end
        end
        STEP: begin
          pos_q     <= b2g(next_bin);
          remaining <= remaining - WIDTH'(1);
          if (remaining == WIDTH'(1)) begin
            state <= DONE;
          end else if (DWELL == 1) begin
            state <= STEP;
          end else begin
            state     <= WAIT;
            dwell_cnt <= DW'(DWELL - 1);
          end
        end
        WAIT: begin
          if (dwell_cnt == DW'(1)) state <= STEP;
          else dwell_cnt <= dwell_cnt - DW'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pos       = pos_q;
  assign bus.up        = up_q;
  assign bus.step      = (state == STEP);
  assign bus.done      = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.cmd_ready = (state == IDLE);

endmodule

// File: tb/tb_gray_seek_ctrl.sv
// Directed bench for gray_seek_ctrl (WIDTH=3, DWELL=4) with a cycle-stamped step/done scoreboard.
module tb_gray_seek_ctrl;

  localparam int W  = 3;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   passed = 0;
  int   failed = 0;
  int   total = 0;

  typedef struct {
    int         cyc;
    bit         is_done;
    logic       up;
    logic [W-1:0] pos;
  } ev_t;

  ev_t          sb[$];
  ev_t          mon_e;
  bit           pend = 1'b0;
  logic [W-1:0] pend_pos;
  logic [W-1:0] mpos;

  gray_seek_ctrl_if #(.WIDTH(W)) bus();

  gray_seek_ctrl #(.WIDTH(W), .DWELL(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] tb_g2b(input logic [W-1:0] g);
    logic [W-1:0] b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [W-1:0] tb_b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Expected step/done events for a command handshaken in cycle t.
  task automatic model_push(input logic [W-1:0] tgt, input int t, output int rdy);
    logic [W-1:0] bp, diff;
    int n;
    bit dn;
    int done_cyc;
    bp   = tb_g2b(mpos);
    diff = tb_g2b(tgt) - bp;
    dn   = 1'b0;
    n    = int'(diff);
`ifdef GRAY_SEEK_SHORTEST_EN
    if (n > (1 << (W - 1))) begin
      dn = 1'b1;
      n  = (1 << W) - n;
    end
`endif
    for (int k = 1; k <= n; k++) begin
      bp = dn ? bp - 1'b1 : bp + 1'b1;
      sb.push_back('{cyc: t + 2 + (k - 1) * DW, is_done: 1'b0, up: !dn, pos: tb_b2g(bp)});
    end
    done_cyc = (n == 0) ? t + 2 : t + 2 + (n - 1) * DW + 1;
    sb.push_back('{cyc: done_cyc, is_done: 1'b1, up: 1'b0, pos: tgt});
    rdy  = done_cyc + 1;
    mpos = tgt;
  endtask

  always @(negedge clk) begin
    if (pend) begin
      chk("step_pos", bus.pos, pend_pos);
      pend = 1'b0;
    end
    if (bus.step === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_step", bus.step, 0);
      else begin
        mon_e = sb.pop_front();
        chk("step_kind", bus.done, mon_e.is_done);
        chk("step_cyc", cyc, mon_e.cyc);
        chk("step_up", bus.up, mon_e.up);
        pend     = 1'b1;
        pend_pos = mon_e.pos;
      end
    end
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_done", bus.done, 0);
      else begin
        mon_e = sb.pop_front();
        chk("done_kind", bus.step, mon_e.is_done ? 0 : 1);
        chk("done_cyc", cyc, mon_e.cyc);
        chk("done_pos", bus.pos, mon_e.pos);
      end
    end
  end

  task automatic wait_ready(input int exp, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) seen = 1'b1;
    end
    if (seen) chk(tag, cyc, exp);
    else chk({tag, "_timeout"}, bus.cmd_ready, 1);
  endtask

  // Called at a negedge of a cycle with cmd_ready high.
  task automatic seek(input logic [W-1:0] tgt, input string tag);
    int t, rdy;
    t = cyc;
    model_push(tgt, t, rdy);
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = tgt;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    wait_ready(rdy, tag);
  endtask

  initial begin
    int t, r1, r2;
    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_target = '0;
    mpos           = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_pos", bus.pos, 0);
    chk("rst_step", bus.step, 0);
    chk("rst_up", bus.up, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ready", bus.cmd_ready, 1);

    seek(3'b010, "ready_up3");
    seek(3'b100, "ready_tie");
    seek(3'b001, "ready_wrap");
    seek(3'b101, "ready_down");
    seek(3'b101, "ready_zero");

    // Second command held on cmd_valid throughout the first seek.
    t = cyc;
    model_push(3'b000, t, r1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = 3'b000;
    @(posedge clk); #1;
    bus.cmd_target = 3'b011;
    model_push(3'b011, r1, r2);
    wait_ready(r1, "ready_held1");
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    wait_ready(r2, "ready_held2");

    // Abort a 3-step seek while it is dwelling after the first step.
    t = cyc;
    model_push(3'b111, t, r1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = 3'b111;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    while (cyc < t + 4) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    mpos  = '0;
    @(negedge clk);
    chk("abort_pos", bus.pos, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_ready", bus.cmd_ready, 1);
    chk("abort_up", bus.up, 0);
    for (int i = 0; i < 10; i++) begin
      chk("abort_no_done", bus.done, 0);
      @(negedge clk);
    end

    seek(3'b110, "ready_after_abort");
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gray_seek_ctrl.md
# gray_seek_ctrl

Seek controller for the reflected-Gray position counter. It accepts a Gray-coded target through a valid/ready handshake and steps an internal Gray position register toward it, one code per step, with a programmable dwell between steps. It issues `step`/`up` strobes to downstream logic such as LED drivers or mirrored counters, and signals completion with a `done` pulse. It sits between the switch/command front end and the Gray counter display path.

## Interface
- `WIDTH`, default 3: Gray code width. Must be ≥ 2.
- `DWELL`, default 4: cycles from one step pulse to the next. Must be ≥ 1.
- `clk`  in  1: clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: target command present.
- `cmd_target`  in  WIDTH: target position, reflected Gray code.
- `cmd_ready`  out  1: controller can accept a command.
- `pos`  out  WIDTH: current position, Gray code, registered.
- `step`  out  1: one-cycle pulse; `pos` advances at the end of this cycle.
- `up`  out  1: direction of the current or last step; 1 = up, 0 = down.
- `busy`  out  1: a seek is in progress.
- `done`  out  1: one-cycle pulse when a seek completes.

## Operation
- Internal arithmetic:
  - Gray-to-binary: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i].
  - Binary-to-Gray: g = b ^ (b>>1).
  - diff = (bin(target) − bin(pos)) mod 2^WIDTH, held as an unsigned WIDTH-bit value.
  - Position wraps modulo 2^WIDTH in both directions. For example, WIDTH=3 up from 100 gives 000; down from 000 gives 100.
- FSM states are IDLE, DECIDE, STEP, WAIT, DONE.
- IDLE:
  - `cmd_ready`=1.
  - A handshake occurs when `cmd_valid` && `cmd_ready`. The target is latched and the FSM goes to DECIDE.
- DECIDE:
  - Computes direction and remaining step count (WIDTH bits, range 0..2^WIDTH−1).
  - diff=0: go to DONE.
  - diff ≤ 2^(WIDTH−1): dir=up, remaining=diff. A tie at exactly half goes up.
  - diff > 2^(WIDTH−1): dir=down, remaining=2^WIDTH−diff.
  - Otherwise go to STEP.
- STEP:
  - `step`=1 and `up`=dir.
  - At the clock edge, `pos` becomes Gray(bin(pos)±1) and remaining is decremented.
  - If remaining becomes 0, go to DONE.
  - Else if DWELL=1, stay in STEP.
  - Else go to WAIT with the dwell counter loaded to DWELL−1.
- WAIT: the dwell counter decrements each cycle. When it reads 1, go to STEP.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 in DECIDE, STEP, WAIT and DONE; 0 in IDLE. `cmd_ready` = !busy.
- A command presented while busy is ignored and not latched. It is accepted only once `cmd_ready` returns high.
- `pos` changes by exactly one Gray code per step pulse, so exactly one bit toggles per step.
- `up` is registered and holds its last value between steps.
- Reset, including mid-seek, takes effect at the next edge:
  - State goes to IDLE; `pos`=0, `up`=0, counters cleared.
  - No `done` is issued for the aborted seek.

## Timing
- Reset values: `pos`=0, `step`=0, `up`=0, `busy`=0, `done`=0, `cmd_ready`=1.
- Handshake in cycle T; DECIDE in T+1.
- First `step` in T+2; the new `pos` is visible in T+3.
- Step k (k=1..N) is in cycle T+2+(k−1)·DWELL.
- `done` is in cycle T+2+(N−1)·DWELL+1, the same cycle in which `pos` first shows the target.
- `cmd_ready` rises the following cycle. A back-to-back command can be accepted in that cycle.
- Zero-distance seek: `done` in T+2, `cmd_ready` in T+3, no `step`.
- `step`, `busy`, `done` and `cmd_ready` are decoded from the state register: no combinational path from the inputs.

## Configuration
- `GRAY_SEEK_SHORTEST_EN`:
  - Defined: shortest-path direction selection as described in Operation; maximum N = 2^(WIDTH−1).
  - Undefined: DECIDE always selects up with remaining=diff; the down path is never taken; `up` is 1 on every step; maximum N = 2^WIDTH−1.

## Test plan
WIDTH=3, DWELL=4, macro defined unless stated.
- Reset, then target 010 with `pos`=000 → up, three steps in T+2, T+6 and T+10; `pos` goes 001, 011, 010; `done` in T+11; `cmd_ready` in T+12.
- `pos`=010, target 100 (tie, diff=4) → up four steps: 110, 111, 101, 100.
- `pos`=100, target 001 → up with wrap: 000, 001; `done` after 2 steps.
- `pos`=001, target 101 → down three steps: 000, 100, 101, with `up`=0. With the macro undefined → up five steps: 011, 010, 110, 111, 101.
- Target equal to `pos` → no `step`, `done` in T+2, `pos` unchanged. A `cmd_valid` held during a seek is not accepted until `cmd_ready`=1.
- Assert `reset` during WAIT of a 3-step seek → next cycle `pos`=000, `busy`=0, `cmd_ready`=1, no `done` pulse.
